apb_rr_master_arbiter: RTL and testbench
========================================

// Module: apb_rr_master_arbiter
// PURPOSE
// - Shares one APB2 master port between NUM_REQ requesters with round-robin arbitration.
// - Sequences the APB protocol on the shared port: SETUP -> ACCESS.
// - Returns read data, or a timeout error, to the requester that owns the transfer.
// - Drives the PADDR/PWRITE/PWDATA/PENABLE/PSELx inputs of APB_Wrapper in APB_top.
// PARAMETERS
// NUM_REQ       2   number of requesters, 2..8
// ADDR_WIDTH    32  PADDR / req_addr width per requester
// DATA_WIDTH    32  PWDATA / PRDATA / req_wdata / rsp_rdata width
// TIMEOUT       16  ACCESS cycles with PREADY=0 before abort; 0 disables the timeout
// PORTS
// PCLK       in   1                    clock, all logic on rising edge
// PRESETn    in   1                    synchronous active-low reset
// req_valid  in   NUM_REQ              per-requester transfer request
// req_write  in   NUM_REQ              1 = write, 0 = read
// req_addr   in   NUM_REQ*ADDR_WIDTH   packed addresses, requester i at [i*AW +: AW]
// req_wdata  in   NUM_REQ*DATA_WIDTH   packed write data
// req_ready  out  NUM_REQ              one-hot accept (combinational)
// rsp_valid  out  NUM_REQ              one-hot, 1-cycle completion pulse (registered)
// rsp_rdata  out  DATA_WIDTH           read data, valid with rsp_valid
// rsp_err    out  1                    1 = transfer aborted by timeout, valid with rsp_valid
// PADDR      out  ADDR_WIDTH           APB address
// PWRITE     out  1                    APB direction
// PWDATA     out  DATA_WIDTH           APB write data
// PSELx      out  1                    APB slave select
// PENABLE    out  1                    APB enable
// PREADY     in   1                    APB slave ready
// PRDATA     in   DATA_WIDTH           APB read data
// BEHAVIOUR
// - Reset: PRESETn=0 at a PCLK edge -> state IDLE.
//   - All outputs 0: PADDR, PWDATA, PWRITE, PSELx, PENABLE, rsp_*, timeout count.
//   - RR pointer = NUM_REQ-1, so requester 0 has highest priority next.
//   - Reset mid-transfer drops that transfer; no rsp_valid is issued.
// - FSM IDLE/SETUP/ACCESS:
//   - IDLE: PSELx=0, PENABLE=0.
//   - SETUP: PSELx=1, PENABLE=0; lasts exactly 1 cycle, then ACCESS.
//   - ACCESS: PSELx=1, PENABLE=1; held until PREADY=1 or timeout.
// - Accept window: state IDLE, or state ACCESS with PREADY=1.
//   - In the window with any req_valid, req_ready = one-hot winner.
//   - Winner = first valid requester searching from RR pointer+1, wrapping modulo NUM_REQ.
//   - On that edge: PADDR/PWRITE/PWDATA <= winner's fields; owner <= winner; RR pointer <= winner; next state SETUP.
//   - Otherwise req_ready = 0.
// - Back-to-back: ACCESS with PREADY=1 and a pending request -> SETUP directly, no IDLE cycle.
// - Completion: ACCESS and PREADY=1 -> next cycle rsp_valid[owner]=1 and rsp_err=0.
//   - rsp_rdata = PRDATA for reads, 0 for writes.
// - Timeout (TIMEOUT>0):
//   - Counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
//   - When it reaches TIMEOUT: abort. Next cycle rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, state IDLE.
//   - An aborted transfer never chains directly to SETUP.
// - rsp_valid and rsp_err are 0 in every cycle except the completion pulse; rsp_rdata holds its last value.
// - PADDR/PWRITE/PWDATA hold their values in IDLE and change only on accept.
// - Requesters hold req_* stable while req_valid=1 && req_ready=0.
//   - Dropping req_valid before accept withdraws the request legally.
// - Latency: accept edge -> SETUP 1 cycle -> ACCESS >=1 cycle -> rsp_valid 1 cycle after the PREADY edge.
//   - Minimum 3 cycles from accept to response; throughput 1 transfer per 2 cycles back-to-back.
// TESTING
// - Single write: req0 write addr=0x10, data=0xA5A5_0001, PREADY=1.
//   -> PSELx=1/PENABLE=0 for 1 cycle, then PENABLE=1; rsp_valid=01, rsp_err=0.
// - Read with wait states: req1 read addr=0x10, PREADY low 3 ACCESS cycles.
//   -> ACCESS held 4 cycles; rsp_valid=10; rsp_rdata=0xA5A5_0001.
// - Fairness: req_valid=11 held continuously, 4 transfers.
//   -> grant order 0,1,0,1; back-to-back ACCESS->SETUP with no IDLE gap.
// - Timeout: TIMEOUT=16, PREADY stuck 0.
//   -> after 16 ACCESS cycles PSELx=0, rsp_err=1, rsp_rdata=0, state IDLE.
// - Reset in ACCESS: PRESETn=0 for 1 cycle mid-transfer.
//   -> all outputs 0 next cycle, no rsp_valid; next req_valid=11 grants requester 0.

Source files
------------

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter that shares one APB2 master port between NUM_REQ requesters,
// sequencing SETUP/ACCESS and returning read data or a timeout error to the owner.
module apb_rr_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic                          PSELx,
  output logic                          PENABLE,
  input  logic                          PREADY,
  input  logic [DATA_WIDTH-1:0]         PRDATA
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand;
  logic              found;
  logic              accept_win;
  logic              accept;
  logic [TCNT_W-1:0] tcount;

  // Search starts just after the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    accept_win = (state == IDLE) || ((state == ACCESS) && PREADY);
    found      = 1'b0;
    win_idx    = '0;
    cand       = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == PTR_W'(NUM_REQ - 1)) ? '0 : cand + PTR_W'(1);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    accept    = accept_win && found;
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      owner     <= '0;
      tcount    <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        PADDR  <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        PWRITE <= req_write[win_idx];
        PWDATA <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        owner  <= win_idx;
        rr_ptr <= win_idx;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= SETUP;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          tcount  <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= PWRITE ? '0 : PRDATA;
            if (accept) begin
              state   <= SETUP;
              PENABLE <= 1'b0;
            end else begin
              state   <= IDLE;
              PSELx   <= 1'b0;
              PENABLE <= 1'b0;
            end
          end else if (TIMEOUT > 0) begin
            tcount <= tcount + TCNT_W'(1);
            // Abort on the cycle the count reaches TIMEOUT; never chain to SETUP.
            if (tcount == TCNT_W'(TIMEOUT - 1)) begin
              rsp_valid[owner] <= 1'b1;
              rsp_err          <= 1'b1;
              rsp_rdata        <= '0;
              state            <= IDLE;
              PSELx            <= 1'b0;
              PENABLE          <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed testbench for apb_rr_master_arbiter: write, waited read, timeout,
// round-robin fairness with back-to-back transfers, and reset mid-transfer.
module tb_apb_rr_master_arbiter;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSELx;
  logic        PENABLE;
  logic        PREADY;
  logic [31:0] PRDATA;

  int checks = 0;
  int errors = 0;
  int n;

  apb_rr_master_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSELx(PSELx), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] write, input logic pready);
    req_valid = valid;
    req_write = write;
    PREADY    = pready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_psel", PSELx, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    checkOutput("rst_pwrite", PWRITE, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;

    $display("[TB] single write from requester 0");
    req_addr[31:0]  = 32'h10;
    req_wdata[31:0] = 32'hA5A5_0001;
    applyStimulus(2'b01, 2'b01, 1'b1);
    checkOutput("wr_ready", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b1);
    checkOutput("wr_setup_psel", PSELx, 1);
    checkOutput("wr_setup_penable", PENABLE, 0);
    checkOutput("wr_paddr", PADDR, 32'h10);
    checkOutput("wr_pwrite", PWRITE, 1);
    checkOutput("wr_pwdata", PWDATA, 32'hA5A5_0001);
    tick();
    checkOutput("wr_access_psel", PSELx, 1);
    checkOutput("wr_access_penable", PENABLE, 1);
    checkOutput("wr_no_early_rsp", rsp_valid, 2'b00);
    tick();
    checkOutput("wr_rsp_valid", rsp_valid, 2'b01);
    checkOutput("wr_rsp_err", rsp_err, 0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 0);
    checkOutput("wr_idle_psel", PSELx, 0);

    $display("[TB] read with three wait states from requester 1");
    req_addr[63:32] = 32'h10;
    applyStimulus(2'b10, 2'b00, 1'b0);
    checkOutput("rd_ready", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("rd_pwrite", PWRITE, 0);
    checkOutput("rd_setup_penable", PENABLE, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("rd_wait_penable", PENABLE, 1);
      checkOutput("rd_wait_no_rsp", rsp_valid, 2'b00);
      tick();
    end
    PRDATA = 32'hA5A5_0001;
    applyStimulus(2'b00, 2'b00, 1'b1);
    checkOutput("rd_access4_penable", PENABLE, 1);
    tick();
    checkOutput("rd_rsp_valid", rsp_valid, 2'b10);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    checkOutput("rd_rsp_err", rsp_err, 0);
    tick();
    checkOutput("rd_pulse_end", rsp_valid, 2'b00);
    checkOutput("rd_rdata_hold", rsp_rdata, 32'hA5A5_0001);

    $display("[TB] timeout with PREADY stuck low");
    PRDATA = 32'hDEAD_BEEF;
    req_addr[63:32] = 32'h44;
    applyStimulus(2'b10, 2'b00, 1'b0);
    checkOutput("to_ready", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0);
    tick();
    n = 0;
    while (PENABLE === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checkOutput("to_access_cycles", n, 16);
    checkOutput("to_psel", PSELx, 0);
    checkOutput("to_rsp_valid", rsp_valid, 2'b10);
    checkOutput("to_rsp_err", rsp_err, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    tick();
    checkOutput("to_err_pulse_end", rsp_err, 0);
    checkOutput("to_stay_idle", PSELx, 0);

    $display("[TB] fairness with both requesters held valid");
    req_addr[31:0]   = 32'h100;
    req_addr[63:32]  = 32'h200;
    req_wdata[31:0]  = 32'h1111;
    req_wdata[63:32] = 32'h2222;
    applyStimulus(2'b11, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fair_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (i == 3) applyStimulus(2'b00, 2'b00, 1'b1);
      checkOutput("fair_setup_psel", PSELx, 1);
      checkOutput("fair_setup_penable", PENABLE, 0);
      checkOutput("fair_paddr", PADDR, (i % 2 == 0) ? 32'h100 : 32'h200);
      if (i > 0) checkOutput("fair_prev_rsp", rsp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    tick();
    checkOutput("fair_last_rsp", rsp_valid, 2'b10);
    checkOutput("fair_last_rdata", rsp_rdata, 0);
    checkOutput("fair_end_idle", PSELx, 0);

    $display("[TB] reset during ACCESS");
    req_addr[31:0]  = 32'h300;
    req_wdata[31:0] = 32'h1234;
    applyStimulus(2'b01, 2'b01, 1'b0);
    checkOutput("rs_ready", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("rs_in_access", PENABLE, 1);
    PRESETn = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b1);
    tick();
    PRESETn = 1'b1;
    checkOutput("rs_psel", PSELx, 0);
    checkOutput("rs_penable", PENABLE, 0);
    checkOutput("rs_paddr", PADDR, 0);
    checkOutput("rs_pwdata", PWDATA, 0);
    checkOutput("rs_pwrite", PWRITE, 0);
    checkOutput("rs_rsp_valid", rsp_valid, 2'b00);
    checkOutput("rs_rsp_err", rsp_err, 0);
    tick();
    checkOutput("rs_no_late_rsp", rsp_valid, 2'b00);
    checkOutput("rs_idle_psel", PSELx, 0);
    applyStimulus(2'b11, 2'b00, 1'b1);
    checkOutput("rs_rr_first", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b1);
    tick();
    tick();
    checkOutput("rs_after_rsp", rsp_valid, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
